// File: rtl/axis_srl_pkg.sv
// axis_srl_pkg: shared SRL geometry for the registered SRL FIFO
//   P_SRL_AWIDTH : address width of one SRL cell
//   P_SRL_DEPTH  : physical depth of one SRL cell
//   P_CNT_WIDTH  : width of the SRL occupancy counter and the total count
package axis_srl_pkg;
    localparam int P_SRL_AWIDTH = 5;
    localparam int P_SRL_DEPTH = 32;
    localparam int P_CNT_WIDTH = 6;
endpackage

// File: rtl/reg_srl_fifo_srl.sv
// reg_srl_fifo_srl: 1-bit, 32-deep addressable shift register cell without reset
//   clk : clock
//   a   : read address; 0 is the most recently shifted-in bit
//   ce  : shift enable; d enters position 0 and older bits move up one position
//   d   : serial input bit
//   q   : bit at address a, read before the edge
module reg_srl_fifo_srl
    import axis_srl_pkg::*;
(
    input  logic                    clk,
    input  logic [P_SRL_AWIDTH-1:0] a,
    input  logic                    ce,
    input  logic                    d,
    output logic                    q
);
    logic [P_SRL_DEPTH-1:0] sr;
    always_ff @(posedge clk) begin
        if (ce) sr <= {sr[P_SRL_DEPTH-2:0], d};
    end
    assign q = sr[a];
endmodule

// File: rtl/axis_reg_srl_fifo.sv
// axis_reg_srl_fifo: AXI-Stream FIFO built from SRL cells followed by one output register
//   clk, reset : clock, synchronous active-high reset
//   s_valid, s_ready, s_payload : upstream handshake and data; s_ready depends on registers and reset only
//   m_valid, m_ready, m_payload : downstream handshake and registered data
//   count : total entries held (SRL entries plus the output register)
module axis_reg_srl_fifo
    import axis_srl_pkg::*;
#(
    parameter int C_WIDTH = 32,
    parameter int C_DEPTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [C_WIDTH-1:0]     s_payload,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [C_WIDTH-1:0]     m_payload,
    output logic [P_CNT_WIDTH-1:0] count
);
    localparam logic [P_CNT_WIDTH-1:0] DEPTH = P_CNT_WIDTH'(C_DEPTH);
    if (C_DEPTH < 2 || C_DEPTH > P_SRL_DEPTH) begin : g_bad_depth
        $error("C_DEPTH must be in 2..%0d", P_SRL_DEPTH);
    end
    logic [P_CNT_WIDTH-1:0]  srl_cnt;
    logic [P_SRL_AWIDTH-1:0] a;
    logic [C_WIDTH-1:0]      q;
    logic                    push;
    logic                    load;
    assign s_ready = ~reset & (srl_cnt < DEPTH);
    assign push = s_valid & s_ready;
    assign load = (srl_cnt != '0) & (~m_valid | m_ready);
    // oldest entry sits at srl_cnt-1; srl_cnt=32 wraps to 0 in 5 bits, so decrement the low bits
    assign a = (srl_cnt == '0) ? '0 : srl_cnt[P_SRL_AWIDTH-1:0] - P_SRL_AWIDTH'(1);
    assign count = srl_cnt + P_CNT_WIDTH'(m_valid);
    for (genvar i = 0; i < C_WIDTH; i++) begin : g_srl
        reg_srl_fifo_srl u_srl (
            .clk (clk),
            .a   (a),
            .ce  (push),
            .d   (s_payload[i]),
            .q   (q[i])
        );
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            srl_cnt   <= '0;
            m_valid   <= 1'b0;
            m_payload <= '0;
        end else begin
            srl_cnt <= srl_cnt + P_CNT_WIDTH'(push) - P_CNT_WIDTH'(load);
            if (load) begin
                m_valid   <= 1'b1;
                m_payload <= q;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end
endmodule
